// File: rtl/rate_mult_decoder.sv
// Rate multiplier receive-side decoder: counts qualified pulses over 2^W-enable
// windows and presents each window total with a valid/ready handshake.
module rate_mult_decoder #(
  parameter int unsigned W = 16
) (
  input  logic         CK,
  input  logic         RST,
  input  logic         EN,
  input  logic         PULSE,
  input  logic         START,
  input  logic         STOP,
  output logic [W:0]   RESULT,
  output logic         VALID,
  input  logic         READY,
  output logic         OVERRUN,
  output logic         BUSY
);

  localparam int unsigned RW = W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    wc_q, wc_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [RW-1:0]   result_q, result_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            busy_q, busy_d;

  logic            in_run_c;
  logic            count_c;
  logic            win_end_c;
  logic            accept_c;
  logic [RW-1:0]   total_c;

  // State register
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: START takes priority over STOP
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START) state_d = ST_RUN;
      ST_RUN: begin
        if (START)     state_d = ST_RUN;
        else if (STOP) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_run_c  = (state_q == ST_RUN);
  assign count_c   = in_run_c && EN && !START && !STOP;
  assign win_end_c = count_c && (wc_q == {W{1'b1}});
  assign accept_c  = valid_q && READY;
  assign total_c   = acc_q + RW'(PULSE);

  // Window counting, result capture and handshake
  always_comb begin
    wc_d      = wc_q;
    acc_d     = acc_q;
    result_d  = result_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    busy_d    = (state_d == ST_RUN);

    if (START || (in_run_c && STOP)) begin
      wc_d  = '0;
      acc_d = '0;
    end else if (count_c) begin
      wc_d  = wc_q + W'(1);
      acc_d = acc_q + RW'(PULSE);
    end

    if (win_end_c) begin
      wc_d  = '0;
      acc_d = '0;
      if (!valid_q || READY) begin
        result_d = total_c;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept_c) begin
      valid_d = 1'b0;
    end

    // A new window request wipes any earlier loss indication
    if (START) overrun_d = 1'b0;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      wc_q      <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wc_q      <= wc_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign RESULT  = result_q;
  assign VALID   = valid_q;
  assign OVERRUN = overrun_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_rate_mult_decoder.sv
// Scoreboard bench for rate_mult_decoder at W=4: stimulus pushes expected
// window totals, a negedge monitor pops and compares on every accepted result.
module tb_rate_mult_decoder;
  localparam int unsigned W = 4;

  logic         CK = 1'b0;
  logic         RST, EN, PULSE, START, STOP, READY;
  logic [W:0]   RESULT;
  logic         VALID, OVERRUN, BUSY;

  int           checks = 0;
  int           errors = 0;
  logic [W:0]   exp_q[$];
  logic [W:0]   mon_exp;
  logic [W-1:0] mult_n;
  logic [15:0]  pat;

  rate_mult_decoder #(.W(W)) dut (
    .CK(CK), .RST(RST), .EN(EN), .PULSE(PULSE), .START(START), .STOP(STOP),
    .RESULT(RESULT), .VALID(VALID), .READY(READY), .OVERRUN(OVERRUN), .BUSY(BUSY)
  );

  always #5 CK = ~CK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic pulse, input logic start, input logic stop);
    EN = en; PULSE = pulse; START = start; STOP = stop;
    @(posedge CK);
    #1;
  endtask

  // Reference binary rate multiplier: weight 2^(W-1-j) fires when bit j is the lowest zero
  function automatic logic zfun(input logic [W-1:0] n, input logic [W-1:0] c);
    logic ones;
    logic z;
    ones = 1'b1;
    z    = 1'b0;
    for (int j = 0; j < int'(W); j++) begin
      if (ones && !n[j] && c[W-1-j]) z = 1'b1;
      ones = ones & n[j];
    end
    return z;
  endfunction

  // Monitor: every accepted result must match the next expected total
  always @(negedge CK) begin
    if (RST === 1'b0 && VALID === 1'b1 && READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0d required=none", RESULT);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", 32'(RESULT), 32'(mon_exp));
      end
    end
  end

  initial begin
    RST = 1'b1; EN = 1'b0; PULSE = 1'b0; START = 1'b0; STOP = 1'b0; READY = 1'b1;
    @(posedge CK);
    #1;
    check("rst_result", 32'(RESULT), 0);
    check("rst_valid", 32'(VALID), 0);
    check("rst_overrun", 32'(OVERRUN), 0);
    check("rst_busy", 32'(BUSY), 0);
    RST = 1'b0;

    // 1: five pulses in one window
    step(0, 0, 1, 0);
    check("t1_busy", 32'(BUSY), 1);
    pat = 16'h8431;
    exp_q.push_back(5'd5);
    for (int i = 0; i < 16; i++) step(1, pat[i], 0, 0);
    check("t1_valid_rise", 32'(VALID), 1);
    step(0, 0, 0, 0);
    check("t1_valid_drop", 32'(VALID), 0);

    // 2: live multiplier with C=11, two windows
    step(0, 0, 1, 0);
    exp_q.push_back(5'd11);
    exp_q.push_back(5'd11);
    mult_n = 4'd5;
    for (int i = 0; i < 32; i++) begin
      step(1, zfun(mult_n, 4'd11), 0, 0);
      mult_n = mult_n + 4'd1;
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t2_overrun", 32'(OVERRUN), 0);

    // 3: EN every other clock, PULSE stuck high
    step(0, 0, 1, 0);
    exp_q.push_back(5'd16);
    for (int i = 0; i < 32; i++) begin
      step(i % 2 == 1, 1, 0, 0);
      if (i == 30) check("t3_not_early", 32'(VALID), 0);
    end
    check("t3_valid_32clk", 32'(VALID), 1);
    step(0, 0, 0, 0);

    // 4: consumer stalled across two windows
    READY = 1'b0;
    step(0, 0, 1, 0);
    exp_q.push_back(5'd3);
    pat = 16'h0111;
    for (int i = 0; i < 16; i++) step(1, pat[i], 0, 0);
    check("t4_valid1", 32'(VALID), 1);
    check("t4_ovr_first", 32'(OVERRUN), 0);
    pat = 16'h007F;
    for (int i = 0; i < 16; i++) step(1, pat[i], 0, 0);
    check("t4_result_held", 32'(RESULT), 3);
    check("t4_overrun", 32'(OVERRUN), 1);
    READY = 1'b1;
    step(0, 0, 0, 0);
    check("t4_valid_drop", 32'(VALID), 0);
    check("t4_overrun_sticky", 32'(OVERRUN), 1);
    step(0, 0, 1, 0);
    check("t4_start_clr_ovr", 32'(OVERRUN), 0);

    // 5: restart at cycle 9, then STOP while a result is pending
    pat = 16'h0111;
    for (int i = 0; i < 9; i++) step(1, pat[i], 0, 0);
    step(0, 0, 1, 0);
    check("t5_no_partial", 32'(VALID), 0);
    READY = 1'b0;
    exp_q.push_back(5'd2);
    pat = 16'h0408;
    for (int i = 0; i < 16; i++) step(1, pat[i], 0, 0);
    check("t5_result", 32'(RESULT), 2);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    step(0, 0, 0, 1);
    check("t5_stop_busy", 32'(BUSY), 0);
    check("t5_stop_valid", 32'(VALID), 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    check("t5_idle_result", 32'(RESULT), 2);
    READY = 1'b1;
    step(0, 0, 0, 0);
    check("t5_valid_drop", 32'(VALID), 0);

    // START beats STOP; then accept coinciding with window end
    step(0, 0, 1, 1);
    check("t7_start_wins", 32'(BUSY), 1);
    READY = 1'b0;
    exp_q.push_back(5'd4);
    for (int i = 0; i < 16; i++) step(1, i < 4, 0, 0);
    exp_q.push_back(5'd6);
    for (int i = 0; i < 15; i++) step(1, i < 6, 0, 0);
    READY = 1'b1;
    step(1, 0, 0, 0);
    check("t7_valid_kept", 32'(VALID), 1);
    check("t7_new_result", 32'(RESULT), 6);
    step(0, 0, 0, 0);
    check("t7_valid_drop", 32'(VALID), 0);
    check("t7_no_overrun", 32'(OVERRUN), 0);

    // 6: reset mid-window, then a full all-ones window
    step(0, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    RST = 1'b1;
    step(0, 0, 0, 0);
    check("t6_result", 32'(RESULT), 0);
    check("t6_valid", 32'(VALID), 0);
    check("t6_busy", 32'(BUSY), 0);
    check("t6_overrun", 32'(OVERRUN), 0);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
    check("t6_idle_novalid", 32'(VALID), 0);
    step(0, 0, 1, 0);
    exp_q.push_back(5'd16);
    for (int i = 0; i < 16; i++) step(1, 1, 0, 0);
    check("t6_full_result", 32'(RESULT), 16);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
